i2c_mac_eeprom_target: RTL
==========================

Name: i2c_mac_eeprom_target

Overview:
I2C target (responder) that emulates the EUI-48 region of the MAC address EEPROM on the module-side I2C bus. The MAC address reader and transceiver are the initiator; this block is the device they talk to. It is used in simulation benches and on board variants without a populated EEPROM. It oversamples SCL/SDA on the system clock, decodes START/STOP/address/pointer, and serves the MAC bytes as sequential random reads.

Parameters:
I2C_ADDR, 7'h50, 7-bit target address matched after START.
MAC_BASE, 8'hFA, word address of the first MAC byte; occupies MAC_BASE..MAC_BASE+5.
FILL_BYTE, 8'hFF, value returned for word addresses outside the MAC window.

Ports:
clk  input  1  system clock (100 MHz); all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
scl_in  input  1  raw SCL from pad; asynchronous to clk.
sda_in  input  1  raw SDA from pad; asynchronous to clk.
sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
mac  input  48  MAC address; mac[47:40] is served at MAC_BASE, mac[7:0] at MAC_BASE+5.
busy  output  1  high from address match until STOP or a non-matching address.
read_done  output  1  one-cycle pulse when the initiator NACKs a read byte.

Behaviour:
- Reset: sda_oe=0, busy=0, read_done=0, state=IDLE, pointer=8'h00, bit count=0. Reset asserted mid-transfer releases SDA on the same clock edge because the reset is asynchronous.
- Sync: scl_in and sda_in each pass through a 2-FF synchroniser plus one history FF. Edges are detected on the synchronised values. Latency from pad to event is 3 clk.
- START: SDA falls while SCL is high. It is valid in any state, including repeated start. Go to ADDR, clear the bit count, set sda_oe=0.
- STOP: SDA rises while SCL is high. Go to IDLE, sda_oe=0, busy=0. This applies in any state, including mid-byte.
- Sampling and driving: SDA is sampled on the SCL rising edge. sda_oe changes only on the SCL falling edge, never while SCL is high, except for STOP and reset.
- ADDR: shift 8 bits MSB first.
  - If bits[7:1]==I2C_ADDR: enter ADDR_ACK, busy=1, and drive sda_oe=1 for one SCL low-high-low ACK slot.
  - Otherwise: go to IGNORE with sda_oe=0 and stay there until START or STOP.
- After the address ACK:
  - R/W=0 goes to PTR.
  - R/W=1 goes to RDATA and loads the byte at the current pointer.
- PTR: shift 8 bits, then ACK. The pointer is loaded with the received byte. Next state is WDATA.
- WDATA: the region is write-protected. Each received byte is ACKed and discarded. The pointer increments by one per byte, mod 256.
- RDATA:
  - Byte load: on entry, the byte is mac[8*(5-(ptr-MAC_BASE)) +: 8] if ptr is in the window, else FILL_BYTE. mac is sampled at byte-load time.
  - Bit drive: each bit is driven MSB first. sda_oe = ~bit, updated on the SCL falling edge. The first bit is driven on the falling edge that ends the ACK slot.
  - After 8 bits: release SDA and enter RACK. The pointer increments mod 256, so 8'hFF wraps to 8'h00.
- RACK: sample SDA on the SCL rising edge.
  - 0 (ACK): load the next byte and return to RDATA.
  - 1 (NACK): pulse read_done and go to IGNORE with SDA released until STOP or START.
- Bit counter: 3-bit, wraps 7 to 0 at the end of each byte. The ACK slot is tracked by state, not by counter.
- Simultaneous events: if a START/STOP condition coincides with a pending data edge, START/STOP wins.
- Pointer persistence: the pointer survives STOP; only reset clears it. This matches a current-address read.

Test Plan:
- Random read: mac=48'h02_12_34_56_78_9A. Write 0xA0, 0xFA; repeated START; send 0xA1; read 6 bytes, NACK on the last. Required: all three header bytes ACKed; data reads 02 12 34 56 78 9A; read_done pulses once; busy=0 after STOP.
- Address mismatch: send 0xA2 after START. Required: sda_oe stays 0 for all 9 clocks; busy stays 0; the following START with 0xA0 is ACKed normally.
- Wrap and fill: set pointer 0xFE, then read 3 bytes. Required: 0x78, 0x9A, 0xFF (the last from pointer 0x00); pointer ends at 0x01.
- Write protect: write 0xA0, 0xFB, 0x55, 0x66. Required: all bytes ACKed. A subsequent read from 0xFA still returns 02 12 34 56 78 9A.
- Abort: STOP after 4 bits of the second read byte. Required: sda_oe=0 within 3 clk of the STOP edge; state IDLE; no read_done pulse.
- Reset mid-read: assert rst while sda_oe=1. Required: sda_oe=0 immediately; pointer=0x00; a new current-address read returns FILL_BYTE 0xFF.

Source files
------------

// File: rtl/i2c_mac_eeprom_target.sv
// I2C target emulating the EUI-48 window of the MAC EEPROM.
// Oversamples SCL/SDA on clk and serves the MAC bytes as sequential reads.
module i2c_mac_eeprom_target #(
  parameter logic [6:0] I2C_ADDR  = 7'h50,
  parameter logic [7:0] MAC_BASE  = 8'hFA,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [47:0] mac,
  output logic        busy,
  output logic        read_done
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_q, sda_q;
  logic [7:0]  ptr_q, ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  sr_q, sr_d;
  logic [6:0]  tx_q, tx_d;
  logic        ph_q, ph_d;
  logic        rw_q, rw_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        scl_s, scl_h, sda_s, sda_h;
  logic        scl_rise, scl_fall;
  logic        start_ev, stop_ev;
  logic [7:0]  byte_in;
  logic [7:0]  rd_byte;

  function automatic logic [7:0] mac_byte(
    input logic [7:0]  p,
    input logic [47:0] m
  );
    logic [7:0] off;
    off = p - MAC_BASE;
    case (off)
      8'd0:    mac_byte = m[47:40];
      8'd1:    mac_byte = m[39:32];
      8'd2:    mac_byte = m[31:24];
      8'd3:    mac_byte = m[23:16];
      8'd4:    mac_byte = m[15:8];
      8'd5:    mac_byte = m[7:0];
      default: mac_byte = FILL_BYTE;
    endcase
  endfunction

  // Two sync stages plus one history stage per line; idle bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign scl_s    = scl_q[1];
  assign scl_h    = scl_q[2];
  assign sda_s    = sda_q[1];
  assign sda_h    = sda_q[2];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start_ev = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_ev  = scl_s & scl_h & ~sda_h & sda_s;
  assign byte_in  = {sr_q, sda_s};
  assign rd_byte  = mac_byte(ptr_q, mac);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 8'h00;
      cnt_q   <= 3'd0;
      sr_q    <= 7'd0;
      tx_q    <= 7'd0;
      ph_q    <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      ph_q    <= ph_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    ph_d    = ph_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (stop_ev) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ph_d    = 1'b0;
    end else if (start_ev) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      ph_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise) begin
            sr_d  = byte_in[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == I2C_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            sr_d  = byte_in[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = byte_in;
              state_d = PTR_ACK;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            sr_d  = byte_in[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = ptr_q + 8'd1;
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // ph_q=0: waiting for the fall that opens the slot.
          if (scl_fall) begin
            if (!ph_q) begin
              oe_d = 1'b1;
              ph_d = 1'b1;
            end else begin
              ph_d  = 1'b0;
              oe_d  = 1'b0;
              cnt_d = 3'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d = RDATA;
                tx_d    = rd_byte[6:0];
                oe_d    = ~rd_byte[7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              ptr_d   = ptr_q + 8'd1;
              ph_d    = 1'b0;
              state_d = RACK;
            end else begin
              cnt_d = cnt_q + 3'd1;
              oe_d  = ~tx_q[6];
              tx_d  = {tx_q[5:0], 1'b0};
            end
          end
        end
        RACK: begin
          // ph_q marks an ACK seen; next byte goes out on the following fall.
          if (scl_rise) begin
            if (sda_s) begin
              done_d  = 1'b1;
              state_d = IGNORE;
            end else begin
              ph_d = 1'b1;
            end
          end else if (scl_fall && ph_q) begin
            ph_d    = 1'b0;
            cnt_d   = 3'd0;
            tx_d    = rd_byte[6:0];
            oe_d    = ~rd_byte[7];
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = oe_q;
  assign busy      = busy_q;
  assign read_done = done_q;

endmodule
